data_mem_responder: RTL

// - Data-memory responder: the far end of the MEM-stage load/store request interface.
// - Accepts one request at a time (load or store), waits a fixed programmable latency,

---
 rtl/data_mem_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: far end of the MEM-stage load/store request interface.
// Accepts one request at a time, waits LATENCY cycles, performs the storage
// access, then presents the response until the requester takes it. Stall is
// raised toward the pipeline for as long as a request is in flight.
// Optional feature macro: BYTE_ENABLE_EN adds a ReqBE[3:0] per-lane store mask.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
`ifdef BYTE_ENABLE_EN
    input  logic [3:0]  ReqBE,
`endif
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespData,
    output logic        RespErr,
    output logic        Stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_VAL = 4'(LATENCY);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       respData_q, respData_d;
    logic              respErr_q, respErr_d;
`ifdef BYTE_ENABLE_EN
    logic [3:0]        be_q, be_d;
`endif

    logic [31:0]       mem [DEPTH];
    logic [31:0]       memRdata;
    logic [31:0]       wrWord;
    logic              memWe;
    logic              reqErr;

    // A request is bad if it is not word aligned or reaches beyond the storage
    assign reqErr = (|ReqAddr[1:0]) | (|ReqAddr[31:ADDR_W+2]);

    assign memRdata = mem[idx_q];

    assign ReqReady  = (state_q == IDLE);
    assign RespValid = (state_q == RESP);
    assign Stall     = (state_q != IDLE);
    assign RespData  = respData_q;
    assign RespErr   = respErr_q;

`ifdef BYTE_ENABLE_EN
    // Merge enabled store lanes over the current word; a zero mask rewrites the word unchanged
    always_comb begin
        wrWord = memRdata;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                wrWord[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end
`else
    assign wrWord = wdata_q;
`endif

    // Next-state logic: latch the request on accept, count down, access storage, wait for the taker
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        respData_d = respData_q;
        respErr_d  = respErr_q;
        memWe      = 1'b0;
`ifdef BYTE_ENABLE_EN
        be_d       = be_q;
`endif
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    write_d = ReqWrite;
                    idx_d   = ReqAddr[ADDR_W+1:2];
                    wdata_d = ReqWData;
                    err_d   = reqErr;
                    cnt_d   = LAT_VAL;
`ifdef BYTE_ENABLE_EN
                    be_d    = ReqBE;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    respErr_d = err_q;
                    if (write_q) begin
                        respData_d = 32'd0;
                        memWe      = ~err_q;
                    end else begin
                        respData_d = err_q ? 32'd0 : memRdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (RespReady) begin
                    respData_d = 32'd0;
                    respErr_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers; reset abandons any request in flight
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            respData_q <= 32'd0;
            respErr_q  <= 1'b0;
`ifdef BYTE_ENABLE_EN
            be_q       <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            respData_q <= respData_d;
            respErr_q  <= respErr_d;
`ifdef BYTE_ENABLE_EN
            be_q       <= be_d;
`endif
        end
    end

    // Backing storage is deliberately not reset so committed stores survive a reset
    always_ff @(posedge Clk) begin
        if (memWe) begin
            mem[idx_q] <= wrWord;
        end
    end

endmodule
